// File: rtl/v810_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : v810_mem_arb
// Purpose  : V810 memory front end: write buffer, read bypass, EBI grant mux.
// Revision : 1.0  initial release
// ============================================================================
module v810_mem_arb #(
    parameter int WB_DEPTH  = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic                      CLK,
    input  logic                      RES,
    input  logic                      CE,
    // instruction cache port
    input  logic [AW-1:0]             ICIA,
    input  logic                      ICIREQ,
    output logic                      ICIACK,
    output logic [DW-1:0]             ICID,
    // execution unit port
    input  logic [AW-1:0]             EUDA,
    input  logic [DW-1:0]             EUDD_O,
    output logic [DW-1:0]             EUDD_I,
    input  logic [1:0]                EUDBC,
    input  logic [DW/8-1:0]           EUDBE,
    input  logic                      EUDWR,
    input  logic                      EUDMRQ,
    input  logic [1:0]                EUDST,
    input  logic                      EUDREQ,
    output logic                      EUDACK,
    // flush handshake and status
    input  logic                      FLUSHREQ,
    output logic                      FLUSHACK,
    output logic [$clog2(WB_DEPTH):0] WB_COUNT,
    // external bus interface request port
    output logic [AW-1:0]             EA,
    output logic [DW-1:0]             ED_O,
    output logic [1:0]                EBC,
    output logic [DW/8-1:0]           EBE,
    output logic                      EWR,
    output logic                      EMRQ,
    output logic [1:0]                EST,
    output logic                      EREQ,
    input  logic [DW-1:0]             ED_I,
    input  logic                      EACK
);

    localparam int C_PW = $clog2(WB_DEPTH);
    localparam int C_CW = C_PW + 1;
    localparam int C_BW = DW / 8;

    localparam logic [1:0] C_GNT_NONE = 2'd0;
    localparam logic [1:0] C_GNT_WB   = 2'd1;
    localparam logic [1:0] C_GNT_EUD  = 2'd2;
    localparam logic [1:0] C_GNT_ICI  = 2'd3;

    // write buffer storage
    logic [AW-1:0]   r_wb_a   [WB_DEPTH];
    logic [DW-1:0]   r_wb_d   [WB_DEPTH];
    logic [1:0]      r_wb_bc  [WB_DEPTH];
    logic [C_BW-1:0] r_wb_be  [WB_DEPTH];
    logic            r_wb_mrq [WB_DEPTH];
    logic [1:0]      r_wb_st  [WB_DEPTH];

    logic [C_PW-1:0] r_head;
    logic [C_PW-1:0] r_tail;
    logic [C_CW-1:0] r_count;
    logic [1:0]      r_gnt;
    logic [1:0]      w_gnt_nxt;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [C_CW-1:0] w_cnt_eval;
    logic            w_eval;
    logic            w_eu_rd;
    logic            w_ici_rd;
    logic            w_hazard;
    logic            w_wb_urgent;
    logic [WB_DEPTH-1:0] w_hit;

    assign w_full = (r_count == C_CW'(WB_DEPTH));
    assign w_pop  = (r_gnt == C_GNT_WB) & EACK & CE & ~RES;
    // A full buffer still takes a write in the cycle its head drains.
    assign w_push = EUDREQ & EUDWR & (~w_full | w_pop) & CE & ~RES;

    // Grant decisions see the buffer as it will be after this cycle's pop.
    assign w_cnt_eval = r_count - C_CW'(w_pop);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_wb_a[r_tail]   <= EUDA;
            r_wb_d[r_tail]   <= EUDD_O;
            r_wb_bc[r_tail]  <= EUDBC;
            r_wb_be[r_tail]  <= EUDBE;
            r_wb_mrq[r_tail] <= EUDMRQ;
            r_wb_st[r_tail]  <= EUDST;
        end
    end

    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_pop)  r_head <= r_head + 1'b1;
                r_count <= r_count + C_CW'(w_push) - C_CW'(w_pop);
            end
        end
    end

    // Per-slot hazard compare; the slot being popped no longer counts.
    for (genvar i = 0; i < WB_DEPTH; i++) begin : g_hazard
        localparam logic [C_PW-1:0] C_IDX = C_PW'(i);
        logic [C_PW-1:0] w_rel;
        logic            w_occ;
        assign w_rel    = C_IDX - r_head;
        assign w_occ    = ({1'b0, w_rel} < r_count) & ~(w_pop & (r_head == C_IDX));
        assign w_hit[i] = w_occ
                        & (r_wb_a[i][AW-1:2] == EUDA[AW-1:2])
                        & (r_wb_mrq[i] == EUDMRQ);
    end

    assign w_hazard = (BYPASS_EN != 0) ? (|w_hit) : (w_cnt_eval != '0);

    // A request being completed by this EACK must not be granted again.
    assign w_eu_rd  = EUDREQ & ~EUDWR & (r_gnt != C_GNT_EUD);
    assign w_ici_rd = ICIREQ & (r_gnt != C_GNT_ICI);
    assign w_eval   = (r_gnt == C_GNT_NONE) | EACK;

    assign w_wb_urgent = (w_cnt_eval != '0)
                       & ((w_cnt_eval == C_CW'(WB_DEPTH)) | FLUSHREQ | (w_eu_rd & w_hazard));

    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) r_gnt <= C_GNT_NONE;
            else     r_gnt <= w_gnt_nxt;
        end
    end

    always_comb begin
        w_gnt_nxt = r_gnt;
        if (w_eval) begin
            if (w_wb_urgent)               w_gnt_nxt = C_GNT_WB;
            else if (w_eu_rd & ~w_hazard)  w_gnt_nxt = C_GNT_EUD;
            else if (w_cnt_eval != '0)     w_gnt_nxt = C_GNT_WB;
            else if (w_ici_rd)             w_gnt_nxt = C_GNT_ICI;
            else                           w_gnt_nxt = C_GNT_NONE;
        end
    end

    always_comb begin
        EA   = '0;
        ED_O = '0;
        EBC  = '0;
        EBE  = '0;
        EWR  = 1'b0;
        EMRQ = 1'b0;
        EST  = '0;
        EREQ = 1'b0;
        case (r_gnt)
            C_GNT_WB: begin
                EA   = r_wb_a[r_head];
                ED_O = r_wb_d[r_head];
                EBC  = r_wb_bc[r_head];
                EBE  = r_wb_be[r_head];
                EWR  = 1'b1;
                EMRQ = r_wb_mrq[r_head];
                EST  = r_wb_st[r_head];
                EREQ = 1'b1;
            end
            C_GNT_EUD: begin
                EA   = EUDA;
                ED_O = EUDD_O;
                EBC  = EUDBC;
                EBE  = EUDBE;
                EWR  = EUDWR;
                EMRQ = EUDMRQ;
                EST  = EUDST;
                EREQ = 1'b1;
            end
            C_GNT_ICI: begin
                EA   = ICIA;
                EBC  = 2'd3;
                EBE  = '1;
                EMRQ = 1'b1;
                EST  = 2'b11;
                EREQ = 1'b1;
            end
            default: begin
                EREQ = 1'b0;
            end
        endcase
        if (RES) begin
            EREQ = 1'b0;
            EWR  = 1'b0;
        end
    end

    assign ICIACK   = (r_gnt == C_GNT_ICI) & EACK & CE & ~RES;
    assign EUDACK   = w_push | ((r_gnt == C_GNT_EUD) & EACK & CE & ~RES);
    assign FLUSHACK = FLUSHREQ & (r_count == '0) & (r_gnt != C_GNT_WB) & ~RES;
    assign ICID     = ED_I;
    assign EUDD_I   = ED_I;
    assign WB_COUNT = r_count;

endmodule
`default_nettype wire

// File: tb/tb_v810_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_v810_mem_arb
// Purpose  : Directed self-checking bench for v810_mem_arb (bypass on and off).
// Revision : 1.0  initial release
// ============================================================================
module tb_v810_mem_arb;

    logic        CLK = 1'b0;
    logic        RES, CE;
    logic [31:0] ICIA, EUDA, EUDD_O, ED_I;
    logic        ICIREQ, EUDWR, EUDMRQ, EUDREQ, FLUSHREQ, EACK;
    logic [1:0]  EUDBC, EUDST;
    logic [3:0]  EUDBE;

    logic        ICIACK, EUDACK, FLUSHACK, EWR, EMRQ, EREQ;
    logic [31:0] ICID, EUDD_I, EA, ED_O;
    logic [2:0]  WB_COUNT;
    logic [1:0]  EBC, EST;
    logic [3:0]  EBE;

    logic        b_iciack, b_eudack, b_flushack, b_ewr, b_emrq, b_ereq;
    logic [31:0] b_icid, b_eudd, b_ea, b_ed_o;
    logic [2:0]  b_wbcnt;
    logic [1:0]  b_ebc, b_est;
    logic [3:0]  b_ebe;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    v810_mem_arb #(.WB_DEPTH(4), .AW(32), .DW(32), .BYPASS_EN(1)) u_dut (
        .CLK(CLK), .RES(RES), .CE(CE),
        .ICIA(ICIA), .ICIREQ(ICIREQ), .ICIACK(ICIACK), .ICID(ICID),
        .EUDA(EUDA), .EUDD_O(EUDD_O), .EUDD_I(EUDD_I), .EUDBC(EUDBC),
        .EUDBE(EUDBE), .EUDWR(EUDWR), .EUDMRQ(EUDMRQ), .EUDST(EUDST),
        .EUDREQ(EUDREQ), .EUDACK(EUDACK),
        .FLUSHREQ(FLUSHREQ), .FLUSHACK(FLUSHACK), .WB_COUNT(WB_COUNT),
        .EA(EA), .ED_O(ED_O), .EBC(EBC), .EBE(EBE), .EWR(EWR), .EMRQ(EMRQ),
        .EST(EST), .EREQ(EREQ), .ED_I(ED_I), .EACK(EACK)
    );

    v810_mem_arb #(.WB_DEPTH(4), .AW(32), .DW(32), .BYPASS_EN(0)) u_dut_nb (
        .CLK(CLK), .RES(RES), .CE(CE),
        .ICIA(ICIA), .ICIREQ(ICIREQ), .ICIACK(b_iciack), .ICID(b_icid),
        .EUDA(EUDA), .EUDD_O(EUDD_O), .EUDD_I(b_eudd), .EUDBC(EUDBC),
        .EUDBE(EUDBE), .EUDWR(EUDWR), .EUDMRQ(EUDMRQ), .EUDST(EUDST),
        .EUDREQ(EUDREQ), .EUDACK(b_eudack),
        .FLUSHREQ(FLUSHREQ), .FLUSHACK(b_flushack), .WB_COUNT(b_wbcnt),
        .EA(b_ea), .ED_O(b_ed_o), .EBC(b_ebc), .EBE(b_ebe), .EWR(b_ewr), .EMRQ(b_emrq),
        .EST(b_est), .EREQ(b_ereq), .ED_I(ED_I), .EACK(EACK)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        EUDREQ = 1'b1; EUDWR = 1'b1; EUDA = a; EUDD_O = d; EUDBE = be;
        EUDMRQ = 1'b1; EUDBC = 2'd3; EUDST = 2'b10;
    endtask

    task automatic rd(input logic [31:0] a);
        EUDREQ = 1'b1; EUDWR = 1'b0; EUDA = a; EUDBE = 4'hf;
        EUDMRQ = 1'b1; EUDBC = 2'd3; EUDST = 2'b01;
    endtask

    task automatic do_reset();
        RES = 1'b1; EUDREQ = 1'b0; EACK = 1'b0; ICIREQ = 1'b0; FLUSHREQ = 1'b0; CE = 1'b1;
        step();
        RES = 1'b0;
    endtask

    initial begin
        RES = 1'b1; CE = 1'b1; ICIA = '0; EUDA = '0; EUDD_O = '0; ED_I = '0;
        ICIREQ = 1'b0; EUDWR = 1'b0; EUDMRQ = 1'b0; EUDREQ = 1'b0; FLUSHREQ = 1'b0;
        EACK = 1'b0; EUDBC = '0; EUDST = '0; EUDBE = '0;

        // reset: requests present but all handshakes held low
        step(); step();
        wr(32'h0, 32'h0, 4'hf); FLUSHREQ = 1'b1;
        #1;
        chk("rst_ereq", EREQ, 1'b0);
        chk("rst_ewr", EWR, 1'b0);
        chk("rst_eudack", EUDACK, 1'b0);
        chk("rst_flushack", FLUSHACK, 1'b0);
        chk("rst_count", WB_COUNT, 3'd0);
        step();
        do_reset();

        // four zero-latency writes fill the buffer, fifth stalls
        for (int k = 0; k < 4; k++) begin
            wr(32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 4'hf);
            #1;
            chk("fill_ack", EUDACK, 1'b1);
            chk("fill_cnt", WB_COUNT, 3'(k));
            step();
        end
        wr(32'h110, 32'hA4, 4'hf);
        #1;
        chk("full_stall", EUDACK, 1'b0);
        chk("full_cnt", WB_COUNT, 3'd4);
        chk("full_ereq", EREQ, 1'b1);
        chk("full_ea", EA, 32'h100);
        chk("full_ewr", EWR, 1'b1);
        step();
        EACK = 1'b1;
        #1;
        chk("full_pushpop_ack", EUDACK, 1'b1);
        step();
        EACK = 1'b0; EUDREQ = 1'b0;
        #1;
        chk("full_cnt_hold", WB_COUNT, 3'd4);
        chk("full_next_head", EA, 32'h104);
        do_reset();

        // bypass: non-hazard read overtakes buffered write
        wr(32'h1000, 32'h11, 4'hf);
        step();
        rd(32'h2000);
        #1;
        chk("byp_idle", EREQ, 1'b0);
        step();
        #1;
        chk("byp_ea", EA, 32'h2000);
        chk("byp_ewr", EWR, 1'b0);
        EACK = 1'b1; ED_I = 32'hDEADBEEF;
        #1;
        chk("byp_ack", EUDACK, 1'b1);
        chk("byp_data", EUDD_I, 32'hDEADBEEF);
        chk("byp_cnt", WB_COUNT, 3'd1);
        step();
        EUDREQ = 1'b0; EACK = 1'b0;
        #1;
        chk("byp_wb_ea", EA, 32'h1000);
        chk("byp_wb_ewr", EWR, 1'b1);
        EACK = 1'b1;
        step();
        EACK = 1'b0;
        #1;
        chk("byp_drained", WB_COUNT, 3'd0);
        do_reset();

        // hazard: same word drains first, then read issues back-to-back
        wr(32'h1002, 32'hCAFE0000, 4'b1100);
        step();
        rd(32'h1000);
        step();
        #1;
        chk("haz_ewr", EWR, 1'b1);
        chk("haz_ea", EA, 32'h1002);
        chk("haz_ebe", EBE, 4'b1100);
        chk("haz_edo", ED_O, 32'hCAFE0000);
        EACK = 1'b1;
        #1;
        chk("haz_noack", EUDACK, 1'b0);
        step();
        EACK = 1'b0;
        #1;
        chk("haz_rd_ea", EA, 32'h1000);
        chk("haz_rd_ewr", EWR, 1'b0);
        chk("haz_cnt", WB_COUNT, 3'd0);
        EACK = 1'b1; ED_I = 32'h12345678;
        #1;
        chk("haz_rd_ack", EUDACK, 1'b1);
        chk("haz_rd_data", EUDD_I, 32'h12345678);
        step();
        EUDREQ = 1'b0; EACK = 1'b0;
        #1;
        chk("haz_idle", EREQ, 1'b0);
        do_reset();

        // no bypass: any read waits for the buffer to empty
        wr(32'h1000, 32'h11, 4'hf);
        step();
        rd(32'h2000);
        step();
        #1;
        chk("nb_ereq", b_ereq, 1'b1);
        chk("nb_ewr", b_ewr, 1'b1);
        chk("nb_ea", b_ea, 32'h1000);
        EACK = 1'b1;
        #1;
        chk("nb_noack", b_eudack, 1'b0);
        step();
        EACK = 1'b0;
        #1;
        chk("nb_rd_ea", b_ea, 32'h2000);
        chk("nb_rd_ewr", b_ewr, 1'b0);
        chk("nb_cnt", b_wbcnt, 3'd0);
        EACK = 1'b1; ED_I = 32'h77;
        #1;
        chk("nb_rd_ack", b_eudack, 1'b1);
        chk("nb_rd_data", b_eudd, 32'h77);
        step();
        do_reset();

        // flush with pending fetch
        for (int k = 0; k < 3; k++) begin
            wr(32'h300 + 32'(4 * k), 32'hB0 + 32'(k), 4'hf);
            step();
        end
        EUDREQ = 1'b0; FLUSHREQ = 1'b1; ICIREQ = 1'b1; ICIA = 32'h8000;
        for (int k = 0; k < 3; k++) begin
            EACK = 1'b1;
            #1;
            chk("fl_ea", EA, 32'h300 + 32'(4 * k));
            chk("fl_ewr", EWR, 1'b1);
            chk("fl_noack", FLUSHACK, 1'b0);
            step();
        end
        EACK = 1'b0;
        #1;
        chk("fl_ack", FLUSHACK, 1'b1);
        chk("ici_ea", EA, 32'h8000);
        chk("ici_ebc", EBC, 2'd3);
        chk("ici_est", EST, 2'b11);
        chk("ici_ebe", EBE, 4'hf);
        chk("ici_ewr", EWR, 1'b0);
        chk("ici_emrq", EMRQ, 1'b1);
        FLUSHREQ = 1'b0; EACK = 1'b1; ED_I = 32'h55;
        #1;
        chk("ici_ack", ICIACK, 1'b1);
        chk("ici_data", ICID, 32'h55);
        step();
        ICIREQ = 1'b0; EACK = 1'b0;
        #1;
        chk("ici_idle", EREQ, 1'b0);

        // reset in the middle of a write-buffer transfer
        wr(32'h400, 32'hC0, 4'hf);
        step();
        wr(32'h404, 32'hC1, 4'hf);
        step();
        EUDREQ = 1'b0;
        #1;
        chk("mr_ereq", EREQ, 1'b1);
        chk("mr_cnt", WB_COUNT, 3'd2);
        RES = 1'b1;
        #1;
        chk("mr_ereq_res", EREQ, 1'b0);
        step();
        RES = 1'b0;
        #1;
        chk("mr_cnt_clr", WB_COUNT, 3'd0);
        chk("mr_ereq_clr", EREQ, 1'b0);
        step();
        #1;
        chk("mr_none", EREQ, 1'b0);

        // clock enable low freezes all state
        wr(32'h500, 32'hD0, 4'hf);
        step();
        EUDREQ = 1'b0;
        step();
        CE = 1'b0; EACK = 1'b1;
        wr(32'h504, 32'hD1, 4'hf);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ce_noack", EUDACK, 1'b0);
            chk("ce_cnt", WB_COUNT, 3'd1);
            chk("ce_ea", EA, 32'h500);
            chk("ce_ereq", EREQ, 1'b1);
            step();
        end
        CE = 1'b1; EACK = 1'b0; EUDREQ = 1'b0;
        #1;
        chk("ce_resume_cnt", WB_COUNT, 3'd1);
        chk("ce_resume_ereq", EREQ, 1'b1);
        EACK = 1'b1;
        step();
        EACK = 1'b0;
        #1;
        chk("ce_drained", WB_COUNT, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
